// File: rtl/blinky_ctrl_regs.sv
// Host write-port register block for the LED blinky sequencer: synchronizes the XIO bus,
// runs a four-phase write handshake and holds sanitized sequencer configuration.
module blinky_ctrl_regs #(
   parameter logic [23:0] TIMER_LOW_LIMIT = 24'h2625A0,
   parameter logic [3:0]  DEFAULT_MODE    = 4'h2
) (
   input  logic        CLK_50MHZ,
   input  logic        RST,
   input  logic [7:0]  host_data,
   input  logic [2:0]  host_addr,
   input  logic        host_wr,
   output logic        host_ack,
   output logic [3:0]  mode,
   output logic [23:0] timer_value,
   output logic [7:0]  static_value,
   output logic        start_blinky,
   output logic        led_reset,
   output logic        cfg_err,
   output logic        cfg_update
);

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      CAPTURE = 4'b0010,
      ACK     = 4'b0100,
      RECOVER = 4'b1000
   } state_t;

   localparam logic [2:0] ADDR_CTRL    = 3'd0;
   localparam logic [2:0] ADDR_TIMER_L = 3'd1;
   localparam logic [2:0] ADDR_TIMER_M = 3'd2;
   localparam logic [2:0] ADDR_TIMER_H = 3'd3;
   localparam logic [2:0] ADDR_STATIC  = 3'd4;
   localparam logic [2:0] ADDR_ERRCLR  = 3'd7;

   state_t      state, state_next;
   logic [7:0]  data_p0, data_s;
   logic [2:0]  addr_p0, addr_s;
   logic        wr_p0, wr_s;
   logic [7:0]  cap_data;
   logic [2:0]  cap_addr;
   logic [15:0] shadow;
   logic [23:0] timer_cand;

   function automatic logic mode_legal(input logic [3:0] m);
      case (m)
         4'd1, 4'd2, 4'd3, 4'd6, 4'd8: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

   function automatic logic timer_too_low(input logic [23:0] c);
      return c < TIMER_LOW_LIMIT;
   endfunction

   function automatic logic [23:0] timer_clamp(input logic [23:0] c);
      return timer_too_low(c) ? TIMER_LOW_LIMIT : c;
   endfunction

   assign timer_cand = {cap_data, shadow};

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (wr_s) state_next = CAPTURE;
         CAPTURE: state_next = ACK;
         ACK:     if (!wr_s) state_next = RECOVER;
         RECOVER: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         data_p0      <= '0;
         data_s       <= '0;
         addr_p0      <= '0;
         addr_s       <= '0;
         wr_p0        <= 1'b0;
         wr_s         <= 1'b0;
         cap_data     <= '0;
         cap_addr     <= '0;
         shadow       <= '0;
         host_ack     <= 1'b0;
         mode         <= DEFAULT_MODE;
         timer_value  <= TIMER_LOW_LIMIT;
         static_value <= '0;
         start_blinky <= 1'b0;
         led_reset    <= 1'b0;
         cfg_err      <= 1'b0;
         cfg_update   <= 1'b0;
      end else begin
         // two-flop synchronizers for the asynchronous XIO pins
         data_p0 <= host_data;
         data_s  <= data_p0;
         addr_p0 <= host_addr;
         addr_s  <= addr_p0;
         wr_p0   <= host_wr;
         wr_s    <= wr_p0;

         state      <= state_next;
         host_ack   <= (state_next == ACK);
         cfg_update <= (state == CAPTURE) &&
                       ((cap_addr == ADDR_CTRL) || (cap_addr == ADDR_TIMER_H));

         if (state == IDLE && wr_s) begin
            cap_addr <= addr_s;
            cap_data <= data_s;
         end

         // register write happens once, in the single CAPTURE cycle
         if (state == CAPTURE) begin
            case (cap_addr)
               ADDR_CTRL: begin
                  start_blinky <= cap_data[0];
                  led_reset    <= cap_data[1];
                  if (mode_legal(cap_data[7:4])) begin
                     mode <= cap_data[7:4];
                  end else begin
                     mode    <= DEFAULT_MODE;
                     cfg_err <= 1'b1;
                  end
               end
               ADDR_TIMER_L: shadow[7:0]  <= cap_data;
               ADDR_TIMER_M: shadow[15:8] <= cap_data;
               ADDR_TIMER_H: begin
                  timer_value <= timer_clamp(timer_cand);
                  if (timer_too_low(timer_cand)) cfg_err <= 1'b1;
               end
               ADDR_STATIC:  static_value <= cap_data;
               ADDR_ERRCLR:  if (cap_data[0]) cfg_err <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blinky_ctrl_regs.sv
// Directed bench for blinky_ctrl_regs: reset, timer staging/clamp, mode sanitize,
// handshake timing and reset in the middle of a handshake.
module tb_blinky_ctrl_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  host_data = '0;
   logic [2:0]  host_addr = '0;
   logic        host_wr = 1'b0;
   logic        host_ack;
   logic [3:0]  mode;
   logic [23:0] timer_value;
   logic [7:0]  static_value;
   logic        start_blinky;
   logic        led_reset;
   logic        cfg_err;
   logic        cfg_update;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;

   blinky_ctrl_regs dut (
      .CLK_50MHZ    (clk),
      .RST          (rst_n),
      .host_data    (host_data),
      .host_addr    (host_addr),
      .host_wr      (host_wr),
      .host_ack     (host_ack),
      .mode         (mode),
      .timer_value  (timer_value),
      .static_value (static_value),
      .start_blinky (start_blinky),
      .led_reset    (led_reset),
      .cfg_err      (cfg_err),
      .cfg_update   (cfg_update)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      int k;
      @(negedge clk);
      host_addr = a;
      host_data = d;
      @(negedge clk);
      host_wr = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (host_ack !== 1'b1 && k < 20);
      n_checks++;
      if (host_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL write_ack_rise addr=%0d: ack=%b required 1", a, host_ack);
      end
      @(negedge clk);
      host_wr = 1'b0;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (host_ack !== 1'b0 && k < 20);
      n_checks++;
      if (host_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL write_ack_fall addr=%0d: ack=%b required 0", a, host_ack);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (8) begin
         @(negedge clk);
         host_wr   = 1'($urandom_range(0, 1));
         host_data = 8'($urandom);
         host_addr = 3'($urandom);
      end
      host_wr = 1'b0;
      #1;
      n_checks++;
      if ({host_ack, mode, timer_value, static_value, start_blinky, led_reset, cfg_err, cfg_update}
          !== {1'b0, 4'h2, 24'h2625A0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b mode=%h timer=%h static=%h st=%b lr=%b err=%b upd=%b required 0/2/2625a0/00/0/0/0/0",
                  host_ack, mode, timer_value, static_value, start_blinky, led_reset, cfg_err, cfg_update);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (timer_value !== 24'h2625A0 || mode !== 4'h2 || host_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: timer=%h mode=%h ack=%b required 2625a0/2/0", timer_value, mode, host_ack);
      end
   endtask

   task automatic test_atomic_timer();
      int u0;
      u0 = upd_cnt;
      do_write(3'd1, 8'h00);
      do_write(3'd2, 8'h2D);
      n_checks++;
      if (timer_value !== 24'h2625A0) begin
         n_fail++;
         $display("FAIL timer_staged_unchanged: timer=%h required 2625a0", timer_value);
      end
      n_checks++;
      if (upd_cnt - u0 !== 0) begin
         n_fail++;
         $display("FAIL timer_staged_no_update: pulses=%0d required 0", upd_cnt - u0);
      end
      do_write(3'd3, 8'h31);
      n_checks++;
      if (timer_value !== 24'h312D00) begin
         n_fail++;
         $display("FAIL timer_commit: timer=%h required 312d00", timer_value);
      end
      n_checks++;
      if (upd_cnt - u0 !== 1 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timer_commit_flags: pulses=%0d err=%b required 1/0", upd_cnt - u0, cfg_err);
      end
   endtask

   task automatic test_clamp();
      int u0;
      do_write(3'd1, 8'h10);
      do_write(3'd2, 8'h00);
      u0 = upd_cnt;
      do_write(3'd3, 8'h00);
      n_checks++;
      if (timer_value !== 24'h2625A0 || cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL timer_clamp: timer=%h err=%b required 2625a0/1", timer_value, cfg_err);
      end
      n_checks++;
      if (upd_cnt - u0 !== 1) begin
         n_fail++;
         $display("FAIL timer_clamp_update: pulses=%0d required 1", upd_cnt - u0);
      end
      do_write(3'd7, 8'h01);
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL errclr: err=%b required 0", cfg_err);
      end
   endtask

   task automatic test_timer_boundary();
      do_write(3'd1, 8'hA0);
      do_write(3'd2, 8'h25);
      do_write(3'd3, 8'h26);
      n_checks++;
      if (timer_value !== 24'h2625A0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timer_at_limit: timer=%h err=%b required 2625a0/0", timer_value, cfg_err);
      end
      // middle byte 0x25 is kept from the previous staging
      do_write(3'd1, 8'h9F);
      do_write(3'd3, 8'h26);
      n_checks++;
      if (timer_value !== 24'h2625A0 || cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL timer_below_limit: timer=%h err=%b required 2625a0/1", timer_value, cfg_err);
      end
      do_write(3'd7, 8'h00);
      n_checks++;
      if (cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL errclr_bit0_zero: err=%b required 1", cfg_err);
      end
      do_write(3'd7, 8'h01);
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL errclr_again: err=%b required 0", cfg_err);
      end
   endtask

   task automatic test_mode_sanitize();
      int u0;
      u0 = upd_cnt;
      do_write(3'd0, 8'h51);
      n_checks++;
      if (mode !== 4'h2 || start_blinky !== 1'b1 || led_reset !== 1'b0 || cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_illegal: mode=%h st=%b lr=%b err=%b required 2/1/0/1", mode, start_blinky, led_reset, cfg_err);
      end
      n_checks++;
      if (upd_cnt - u0 !== 1) begin
         n_fail++;
         $display("FAIL mode_illegal_update: pulses=%0d required 1", upd_cnt - u0);
      end
      do_write(3'd7, 8'h01);
      do_write(3'd0, 8'h63);
      n_checks++;
      if (mode !== 4'h6 || start_blinky !== 1'b1 || led_reset !== 1'b1 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mode_legal: mode=%h st=%b lr=%b err=%b required 6/1/1/0", mode, start_blinky, led_reset, cfg_err);
      end
      do_write(3'd0, 8'h80);
      n_checks++;
      if (mode !== 4'h8 || start_blinky !== 1'b0 || led_reset !== 1'b0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mode_eight: mode=%h st=%b lr=%b err=%b required 8/0/0/0", mode, start_blinky, led_reset, cfg_err);
      end
   endtask

   task automatic test_static_and_ignored();
      int u0;
      u0 = upd_cnt;
      do_write(3'd4, 8'hC3);
      do_write(3'd5, 8'hFF);
      do_write(3'd6, 8'h00);
      n_checks++;
      if (static_value !== 8'hC3 || mode !== 4'h8 || timer_value !== 24'h2625A0) begin
         n_fail++;
         $display("FAIL static_ignored: static=%h mode=%h timer=%h required c3/8/2625a0", static_value, mode, timer_value);
      end
      n_checks++;
      if (upd_cnt - u0 !== 0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL static_no_update: pulses=%0d err=%b required 0/0", upd_cnt - u0, cfg_err);
      end
   endtask

   task automatic test_handshake_timing();
      int u0, first, low_cycles;
      @(negedge clk);
      host_addr = 3'd0;
      host_data = 8'h13;
      @(negedge clk);
      host_wr = 1'b1;
      u0 = upd_cnt;
      first = -1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (host_ack === 1'b1 && first < 0) first = i;
      end
      n_checks++;
      if (first !== 3) begin
         n_fail++;
         $display("FAIL ack_rise_latency: first edge index=%0d required 3", first);
      end
      n_checks++;
      if (cfg_update !== 1'b1 || mode !== 4'h1) begin
         n_fail++;
         $display("FAIL update_with_ack: upd=%b mode=%h required 1/1", cfg_update, mode);
      end
      low_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (host_ack !== 1'b1) low_cycles++;
      end
      n_checks++;
      if (low_cycles !== 0 || upd_cnt - u0 !== 1) begin
         n_fail++;
         $display("FAIL held_wr_single: ack_low=%0d pulses=%0d required 0/1", low_cycles, upd_cnt - u0);
      end
      @(negedge clk);
      host_wr = 1'b0;
      first = -1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (host_ack === 1'b0 && first < 0) first = i;
      end
      n_checks++;
      if (first !== 2) begin
         n_fail++;
         $display("FAIL ack_fall_latency: first edge index=%0d required 2", first);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_midop();
      int k;
      do_write(3'd1, 8'h11);
      do_write(3'd2, 8'h22);
      @(negedge clk);
      host_addr = 3'd4;
      host_data = 8'h77;
      @(negedge clk);
      host_wr = 1'b1;
      k = 0;
      do begin @(posedge clk); #1; k++; end while (host_ack !== 1'b1 && k < 20);
      n_checks++;
      if (host_ack !== 1'b1 || static_value !== 8'h77) begin
         n_fail++;
         $display("FAIL midop_in_ack: ack=%b static=%h required 1/77", host_ack, static_value);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (host_ack !== 1'b0 || static_value !== 8'h00 || mode !== 4'h2 || timer_value !== 24'h2625A0) begin
         n_fail++;
         $display("FAIL midop_async_reset: ack=%b static=%h mode=%h timer=%h required 0/00/2/2625a0",
                  host_ack, static_value, mode, timer_value);
      end
      host_wr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_write(3'd3, 8'h40);
      n_checks++;
      if (timer_value !== 24'h400000 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_shadow_cleared: timer=%h err=%b required 400000/0", timer_value, cfg_err);
      end
   endtask

   initial begin
      test_reset();
      test_atomic_timer();
      test_clamp();
      test_timer_boundary();
      test_mode_sanitize();
      test_static_and_ignored();
      test_handshake_timing();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
